rgb_conv3x3_stream: RTL
=======================

RGB_CONV3X3_STREAM -- requirements
Module: rgb_conv3x3_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, unsigned pixel bits per colour channel.
REQ-002 SHALL have parameter COEF_WIDTH, default 8, signed weight bits.
REQ-003 SHALL have parameter NUM_FILTERS, default 3, number of parallel output filters.
REQ-004 SHALL have parameters IMG_W and IMG_H, both default 224, input frame size; each SHALL be at least 3.
REQ-005 SHALL derive OUT_W = DATA_WIDTH+COEF_WIDTH+6, signed result bits per filter.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cfg_we  in  1  weight write strobe.
REQ-010 cfg_addr  in  clog2(NUM_FILTERS*27)  weight index = filter*27 + channel*9 + row*3 + col; channel order is r=0, g=1, b=2.
REQ-011 cfg_data  in  COEF_WIDTH  signed weight value.
REQ-012 s_valid / s_ready  in / out  1  input pixel handshake.
REQ-013 s_rgb  in  3*DATA_WIDTH  packed pixel {b,g,r}; r occupies the LSBs.
REQ-014 s_sof  in  1  first pixel of a frame, qualified by s_valid.
REQ-015 m_valid / m_ready  out / in  1  result handshake.
REQ-016 m_data  out  NUM_FILTERS*OUT_W  results; filter 0 occupies the LSBs.
REQ-017 m_last  out  1  final result of the frame.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN:
- IDLE->RUN on an accepted beat with s_sof=1.
- RUN->DRAIN when pixel (row IMG_H-1, col IMG_W-1) is accepted.
- DRAIN->IDLE when the m_last beat is accepted.
REQ-020 In IDLE, beats with s_sof=0 SHALL be accepted and discarded.
REQ-021 SHALL buffer two prior rows of pixels in line buffers of depth IMG_W and form a 3x3x3 window in raster order.
REQ-022 SHALL produce a "valid" (unpadded) result only for windows whose centre lies at row 1..IMG_H-2 and col 1..IMG_W-2, giving (IMG_H-2)*(IMG_W-2) results per frame.
REQ-023 Each filter result SHALL be the signed sum of 27 products (zero-extended pixel x signed weight), computed at full OUT_W precision with no overflow.
REQ-024 Pipeline: one product register stage plus one adder-tree register stage; m_valid SHALL rise exactly 2 cycles after the accepting edge of the pixel that completes a window, absent stalls.
REQ-025 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable and the whole pipeline SHALL freeze.
REQ-026 s_ready SHALL equal !(m_valid && !m_ready) && state!=DRAIN.
REQ-027 An accepted s_sof=1 beat during RUN SHALL abort the current frame:
- clear counters and pipeline valids (no m_last is issued for the aborted frame);
- treat that pixel as row 0, col 0 of a new frame.
REQ-028 cfg_we SHALL take effect only in IDLE; writes in RUN or DRAIN SHALL be ignored.
REQ-029 Column counter SHALL wrap from IMG_W-1 to 0 and increment the row counter.

Reset
REQ-030 On rst_n=0 SHALL force:
- state=IDLE;
- s_ready=0 while reset is asserted and 1 on the first cycle after release;
- m_valid=0, m_last=0, m_data=0, busy=0;
- row/col counters=0.
Weights SHALL reset to 0. Line-buffer contents need no reset.
REQ-031 Reset asserted mid-frame SHALL discard all in-flight results with no further m_valid.

Configuration
REQ-032 With CONV_RELU_EN defined, each filter result SHALL be clamped to 0 when negative, adding no latency.
REQ-033 Without CONV_RELU_EN, results SHALL be the raw signed sums.

Structure
REQ-034 A shared package SHALL hold:
- the OUT_W derivation function;
- the constant 27 (window taps);
- the state enumeration typedef.
REQ-035 Line buffering SHALL be a sub-module conv_line_buffer (parameters: width, depth; one write and two read taps per accepted pixel); the MAC tree stays in the top module.

Verification
REQ-036 All weights 1, constant pixel r=g=b=1, IMG_W=IMG_H=5 -> 9 results, each filter = 27; m_last on the 9th result.
REQ-037 Filter 1 weights all -1, pixel 255, CONV_RELU_EN undefined -> filter 1 = -6885; with CONV_RELU_EN defined -> 0.
REQ-038 m_ready toggling 1-of-3 cycles over a ramp frame -> result sequence identical to the m_ready=1 run; m_data is stable during each stall.
REQ-039 s_sof reasserted at row 2, col 3 of a 5x5 frame -> no m_last for the aborted frame; the next frame yields exactly 9 correct results.
REQ-040 cfg_we during RUN -> weights unchanged and results match the pre-write weights; rst_n pulsed mid-frame -> m_valid=0 next cycle, busy=0, and s_ready=1 after release.

Source files
------------

// File: rtl/rgb_conv3x3_stream_pkg.sv
// Purpose: shared constants, result-width derivation and FSM state type for rgb_conv3x3_stream.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgb_conv3x3_stream_pkg;

  // Taps per output: 3 channels x 3 rows x 3 columns.
  localparam int TAPS = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Signed result width: an unsigned pixel times a signed weight needs data_w+coef_w+1
  // bits; summing 27 of them adds ceil(log2(27)) = 5 more.
  function automatic int conv_out_w(input int data_w, input int coef_w);
    return data_w + coef_w + 6;
  endfunction

endpackage

// File: rtl/rgb_conv3x3_stream_line_buffer.sv
// Purpose: two-row line buffer; per write, returns the same column from the previous two rows.
// Latency: taps are combinational reads of the addressed column, valid before the write edge.
// Backpressure: none; the caller only asserts we on accepted pixels.
// Ports: clk; we (write strobe); addr (column); din (pixel);
//        tap1 (row above, same column); tap2 (two rows above, same column).
module conv_line_buffer #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 224,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap1,
  output logic [WIDTH-1:0] tap2
);

  logic [WIDTH-1:0] row1 [DEPTH];
  logic [WIDTH-1:0] row2 [DEPTH];

  assign tap1 = row1[addr];
  assign tap2 = row2[addr];

  // Writing a column pushes it down one row: the old row-above value becomes two-above.
  always_ff @(posedge clk) begin
    if (we) begin
      row1[addr] <= din;
      row2[addr] <= row1[addr];
    end
  end

endmodule

// File: rtl/rgb_conv3x3_stream.sv
// Purpose: streaming 3x3x3 RGB convolution with NUM_FILTERS parallel signed filters (valid windows only).
// Latency: m_valid rises 2 cycles after the accepting edge of the pixel that completes a window.
// Backpressure: m_valid && !m_ready freezes the whole pipeline and drops s_ready; s_ready is also low in DRAIN.
// Ports: clk, rst_n (async, active-low); cfg_we/cfg_addr/cfg_data weight writes (IDLE only,
//        addr = filter*27 + channel*9 + row*3 + col, channel r=0 g=1 b=2);
//        s_valid/s_ready/s_rgb {b,g,r}/s_sof pixel input; m_valid/m_ready/m_data (filter 0 in LSBs)/m_last
//        result output; busy = not IDLE.
// Build option: define CONV_RELU_EN to clamp negative results to 0 (no extra latency).
module rgb_conv3x3_stream
  import rgb_conv3x3_stream_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int COEF_WIDTH  = 8,
  parameter  int NUM_FILTERS = 3,
  parameter  int IMG_W       = 224,
  parameter  int IMG_H       = 224,
  localparam int OUT_W       = conv_out_w(DATA_WIDTH, COEF_WIDTH),
  localparam int NW          = NUM_FILTERS * TAPS,
  localparam int AW          = $clog2(NW)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [AW-1:0]                cfg_addr,
  input  logic signed [COEF_WIDTH-1:0] cfg_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [3*DATA_WIDTH-1:0]      s_rgb,
  input  logic                         s_sof,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_FILTERS*OUT_W-1:0] m_data,
  output logic                         m_last,
  output logic                         busy
);

  localparam int PW  = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int PXW = 3 * DATA_WIDTH;
  localparam int CLW = $clog2(IMG_W);
  localparam int RWW = $clog2(IMG_H);
  localparam logic [CLW-1:0] COL_MAX = CLW'(IMG_W - 1);
  localparam logic [RWW-1:0] ROW_MAX = RWW'(IMG_H - 1);

  state_t state, state_nxt;
  logic [CLW-1:0] col, cur_col;
  logic [RWW-1:0] row, cur_row;
  logic stall, accept, frame_acc, abort, win_done, frame_end;
  logic w_vld, w_last, p_vld, p_last;
  logic [PXW-1:0] tap1, tap2;
  logic [PXW-1:0] win [3][3];  // [window row][window col], col 2 = newest
  logic signed [COEF_WIDTH-1:0] wt [NW];
  logic signed [PW-1:0]    prod     [NUM_FILTERS][TAPS];
  logic signed [PW-1:0]    prod_nxt [NUM_FILTERS][TAPS];
  logic signed [OUT_W-1:0] sum      [NUM_FILTERS];
  logic signed [OUT_W-1:0] res      [NUM_FILTERS];

  assign stall   = m_valid && !m_ready;
  assign s_ready = rst_n && !stall && (state != ST_DRAIN);
  assign busy    = (state != ST_IDLE);
  assign accept  = s_valid && s_ready;
  assign abort   = accept && s_sof && (state == ST_RUN);
  // Pixels that belong to a frame; non-sof beats in IDLE are swallowed.
  assign frame_acc = accept && (s_sof || (state == ST_RUN));

  // An sof beat is always row 0, col 0 of a fresh frame, whatever the counters say.
  assign cur_col   = s_sof ? '0 : col;
  assign cur_row   = s_sof ? '0 : row;
  assign win_done  = (cur_row >= RWW'(2)) && (cur_col >= CLW'(2));
  assign frame_end = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept && s_sof) state_nxt = ST_RUN;
      ST_RUN:   if (frame_acc && frame_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (m_valid && m_ready && m_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (frame_acc) begin
      if (cur_col == COL_MAX) begin
        col <= '0;
        row <= frame_end ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) wt[i] <= '0;
    end else if (cfg_we && (state == ST_IDLE) && (int'(cfg_addr) < NW)) begin
      wt[cfg_addr] <= cfg_data;
    end
  end

  conv_line_buffer #(
    .WIDTH (PXW),
    .DEPTH (IMG_W)
  ) u_line_buffer (
    .clk  (clk),
    .we   (frame_acc),
    .addr (cur_col),
    .din  (s_rgb),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // Zero-extend each pixel channel and multiply by its signed weight.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_nxt[f][t] = PW'($signed({1'b0, win[(t % 9) / 3][t % 3][(t / 9) * DATA_WIDTH +: DATA_WIDTH]}))
                       * PW'(wt[f * TAPS + t]);
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      sum[f] = '0;
      for (int t = 0; t < TAPS; t++) sum[f] = sum[f] + OUT_W'(prod[f][t]);
`ifdef CONV_RELU_EN
      res[f] = sum[f][OUT_W-1] ? '0 : sum[f];
`else
      res[f] = sum[f];
`endif
    end
  end

  // Datapath registers (window and products) need no reset; validity travels separately.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (frame_acc) begin
        for (int k = 0; k < 3; k++) begin
          win[k][0] <= win[k][1];
          win[k][1] <= win[k][2];
        end
        win[0][2] <= tap2;
        win[1][2] <= tap1;
        win[2][2] <= s_rgb;
      end
      prod <= prod_nxt;
    end
  end

  // Valid/last pipeline; an abort drops everything still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_vld   <= 1'b0;
      w_last  <= 1'b0;
      p_vld   <= 1'b0;
      p_last  <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (!stall) begin
      w_vld   <= frame_acc && win_done;
      w_last  <= frame_acc && frame_end;
      p_vld   <= w_vld && !abort;
      p_last  <= w_last && !abort;
      m_valid <= p_vld && !abort;
      m_last  <= p_last && !abort;
      if (p_vld) begin
        for (int f = 0; f < NUM_FILTERS; f++) m_data[f*OUT_W +: OUT_W] <= res[f];
      end
    end
  end

endmodule
